// File: rtl/sort4_pkg.sv
// rtl/sort4_pkg.sv - shared constants and state type for the four-element sorter
package sort4_pkg;

  localparam int ELEM_W = 3;
  localparam int N_ELEM = 4;
  localparam int VEC_W  = ELEM_W * N_ELEM;

  localparam int OFF_V0 = 0;
  localparam int OFF_V1 = 3;
  localparam int OFF_V2 = 6;
  localparam int OFF_V3 = 9;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_e;

endpackage

// File: rtl/bit3_comparator.sv
// rtl/bit3_comparator.sv - combinational magnitude comparator for two 3-bit unsigned values
module bit3_comparator (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/sort4_ctrl.sv
// rtl/sort4_ctrl.sv - bubble-sort sequencer for four 3-bit values sharing one comparator
module sort4_ctrl
  import sort4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] dout,
  output logic [2:0]       swaps
);

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   r_q [N_ELEM];
  logic [ELEM_W-1:0]   r_d [N_ELEM];
  logic [1:0]          i_q, i_d;
  logic [1:0]          plen_q, plen_d;
  logic                sw_q, sw_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [VEC_W-1:0]    dout_q, dout_d;
  logic [2:0]          swaps_q, swaps_d;
  logic                done_q, done_d;

  logic [ELEM_W-1:0]   cmp_a, cmp_b;
  logic                cmp_gt, cmp_eq, cmp_lt;
  logic                do_swap;
  logic                pass_sw;
  logic [1:0]          i_nxt;

  assign i_nxt = i_q + 2'd1;
  assign cmp_a = r_q[i_q];
  assign cmp_b = r_q[i_nxt];

  bit3_comparator u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (cmp_gt),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  // Only a strict greater-than swaps, which keeps equal values in order.
  assign do_swap = cmp_gt && !(cmp_eq || cmp_lt);
  assign pass_sw = sw_q || do_swap;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    i_d     = i_q;
    plen_d  = plen_q;
    sw_d    = sw_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    swaps_d = swaps_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          r_d[0]  = din[OFF_V0 +: ELEM_W];
          r_d[1]  = din[OFF_V1 +: ELEM_W];
          r_d[2]  = din[OFF_V2 +: ELEM_W];
          r_d[3]  = din[OFF_V3 +: ELEM_W];
          i_d     = 2'd0;
          plen_d  = 2'd3;
          sw_d    = 1'b0;
          cnt_d   = 3'd0;
          state_d = CMP;
        end
      end

      CMP: begin
        if (do_swap) begin
          r_d[i_q]   = cmp_b;
          r_d[i_nxt] = cmp_a;
          cnt_d      = cnt_q + 3'd1;
        end
        if (i_q < (plen_q - 2'd1)) begin
          i_d  = i_nxt;
          sw_d = pass_sw;
        end else if ((plen_q == 2'd1) || !pass_sw) begin
          sw_d    = pass_sw;
          state_d = DONE;
        end else begin
          plen_d = plen_q - 2'd1;
          i_d    = 2'd0;
          sw_d   = 1'b0;
        end
      end

      DONE: begin
        dout_d[OFF_V0 +: ELEM_W] = r_q[0];
        dout_d[OFF_V1 +: ELEM_W] = r_q[1];
        dout_d[OFF_V2 +: ELEM_W] = r_q[2];
        dout_d[OFF_V3 +: ELEM_W] = r_q[3];
        swaps_d = cnt_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int k = 0; k < N_ELEM; k++) r_q[k] <= '0;
      i_q     <= 2'd0;
      plen_q  <= 2'd3;
      sw_q    <= 1'b0;
      cnt_q   <= 3'd0;
      dout_q  <= '0;
      swaps_q <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      i_q     <= i_d;
      plen_q  <= plen_d;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      swaps_q <= swaps_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == CMP);
  assign done  = done_q;
  assign dout  = dout_q;
  assign swaps = swaps_q;

endmodule
